sw_gauss_filter_ctrl: RTL

Master-side counterpart to the image memory's sliding-window read and filtered-pixel write interfaces.
- Scans every 3x3 window of the stored image and requests it via rd/addr_row_r/addr_col_r.
- Captures the nine returned window pixels and applies a 3x3 Gaussian kernel (1-2-1 / 2-4-2 / 1-2-1, /16, rounded).
- Writes each result back at the window centre via wr/addr_row_w/addr_col_w/cl_pixel.
- Sits between the top-level controller (start/done) and the image memory.

---
 rtl/sw_gauss_filter_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sw_gauss_filter_ctrl.sv
// Sliding-window Gaussian filter controller: scans every 3x3 window of the image memory,
// filters it with the 1-2-1/2-4-2/1-2-1 kernel and writes the result back at the window centre.
module sw_gauss_filter_ctrl #(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  sw_pixel_1,
    input  logic [7:0]  sw_pixel_2,
    input  logic [7:0]  sw_pixel_3,
    input  logic [7:0]  sw_pixel_4,
    input  logic [7:0]  sw_pixel_5,
    input  logic [7:0]  sw_pixel_6,
    input  logic [7:0]  sw_pixel_7,
    input  logic [7:0]  sw_pixel_8,
    input  logic [7:0]  sw_pixel_9,
    output logic        rd,
    output logic [7:0]  addr_row_r,
    output logic [7:0]  addr_col_r,
    output logic        wr,
    output logic [7:0]  addr_row_w,
    output logic [7:0]  addr_col_w,
    output logic [7:0]  cl_pixel,
    output logic        busy,
    output logic        done,
    output logic [15:0] pix_cnt
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUM_W  = 12;
    localparam int unsigned PH_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [ADDR_W-1:0]   r_row,        w_row_nxt;
    logic [ADDR_W-1:0]   r_col,        w_col_nxt;
    logic [PH_W-1:0]     r_phase,      w_phase_nxt;
    logic                r_rd,         w_rd_nxt;
    logic                r_wr,         w_wr_nxt;
    logic [ADDR_W-1:0]   r_addr_row_r, w_addr_row_r_nxt;
    logic [ADDR_W-1:0]   r_addr_col_r, w_addr_col_r_nxt;
    logic [ADDR_W-1:0]   r_addr_row_w, w_addr_row_w_nxt;
    logic [ADDR_W-1:0]   r_addr_col_w, w_addr_col_w_nxt;
    logic [PIX_W-1:0]    r_cl_pixel,   w_cl_pixel_nxt;
    logic                r_busy,       w_busy_nxt;
    logic                r_done,       w_done_nxt;
    logic [CNT_W-1:0]    r_pix_cnt,    w_pix_cnt_nxt;

    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_sum_rnd;
    logic [PIX_W-1:0]    w_result;
    logic                w_rd_end;
    logic                w_wr_end;
    logic                w_col_more;
    logic                w_row_more;

    // Kernel weights are powers of two, so the MAC reduces to shifted adds; max 4080 + 8 fits 12 bits.
    assign w_sum = SUM_W'(sw_pixel_1)        + (SUM_W'(sw_pixel_2) << 1) + SUM_W'(sw_pixel_3)
                 + (SUM_W'(sw_pixel_4) << 1) + (SUM_W'(sw_pixel_5) << 2) + (SUM_W'(sw_pixel_6) << 1)
                 + SUM_W'(sw_pixel_7)        + (SUM_W'(sw_pixel_8) << 1) + SUM_W'(sw_pixel_9);
    assign w_sum_rnd = w_sum + SUM_W'(8);
    assign w_result  = w_sum_rnd[SUM_W-1:4];

    assign w_rd_end   = (r_phase == PH_W'(RD_LAT - 1));
    assign w_wr_end   = (r_phase == PH_W'(WR_LAT - 1));
    assign w_col_more = (r_col < ADDR_W'(IMG_W - 3));
    assign w_row_more = (r_row < ADDR_W'(IMG_H - 3));

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_phase      <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr_row_r <= '0;
            r_addr_col_r <= '0;
            r_addr_row_w <= '0;
            r_addr_col_w <= '0;
            r_cl_pixel   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pix_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_phase      <= w_phase_nxt;
            r_rd         <= w_rd_nxt;
            r_wr         <= w_wr_nxt;
            r_addr_row_r <= w_addr_row_r_nxt;
            r_addr_col_r <= w_addr_col_r_nxt;
            r_addr_row_w <= w_addr_row_w_nxt;
            r_addr_col_w <= w_addr_col_w_nxt;
            r_cl_pixel   <= w_cl_pixel_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pix_cnt    <= w_pix_cnt_nxt;
        end
    end

    // Next-state and next-output logic; outputs are loaded on the edge that enters each state
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_phase_nxt      = r_phase;
        w_rd_nxt         = r_rd;
        w_wr_nxt         = r_wr;
        w_addr_row_r_nxt = r_addr_row_r;
        w_addr_col_r_nxt = r_addr_col_r;
        w_addr_row_w_nxt = r_addr_row_w;
        w_addr_col_w_nxt = r_addr_col_w;
        w_cl_pixel_nxt   = r_cl_pixel;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_pix_cnt_nxt    = r_pix_cnt;

        unique case (r_state)
            S_IDLE: begin
                w_rd_nxt   = 1'b0;
                w_wr_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt      = S_READ;
                    w_row_nxt        = '0;
                    w_col_nxt        = '0;
                    w_phase_nxt      = '0;
                    w_pix_cnt_nxt    = '0;
                    w_rd_nxt         = 1'b1;
                    w_addr_row_r_nxt = '0;
                    w_addr_col_r_nxt = '0;
                    w_busy_nxt       = 1'b1;
                end
            end

            S_READ: begin
                if (w_rd_end) begin
                    w_state_nxt = S_CALC;
                    w_phase_nxt = '0;
                    w_rd_nxt    = 1'b0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            S_CALC: begin
                w_state_nxt      = S_WRITE;
                w_wr_nxt         = 1'b1;
                w_addr_row_w_nxt = r_row + ADDR_W'(1);
                w_addr_col_w_nxt = r_col + ADDR_W'(1);
                w_cl_pixel_nxt   = w_result;
            end

            S_WRITE: begin
                if (w_wr_end) begin
                    w_phase_nxt   = '0;
                    w_wr_nxt      = 1'b0;
                    w_pix_cnt_nxt = r_pix_cnt + CNT_W'(1);
                    if (w_col_more) begin
                        w_state_nxt      = S_READ;
                        w_col_nxt        = r_col + ADDR_W'(1);
                        w_rd_nxt         = 1'b1;
                        w_addr_row_r_nxt = r_row;
                        w_addr_col_r_nxt = r_col + ADDR_W'(1);
                    end else begin
                        w_col_nxt = '0;
                        if (w_row_more) begin
                            w_state_nxt      = S_READ;
                            w_row_nxt        = r_row + ADDR_W'(1);
                            w_rd_nxt         = 1'b1;
                            w_addr_row_r_nxt = r_row + ADDR_W'(1);
                            w_addr_col_r_nxt = '0;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd         = r_rd;
    assign wr         = r_wr;
    assign addr_row_r = r_addr_row_r;
    assign addr_col_r = r_addr_col_r;
    assign addr_row_w = r_addr_row_w;
    assign addr_col_w = r_addr_col_w;
    assign cl_pixel   = r_cl_pixel;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pix_cnt    = r_pix_cnt;

endmodule
